// File: rtl/wddl_dr_capture_32.sv
`default_nettype none
// ============================================================================
//  Module      : wddl_dr_capture_32
//  Description : Dual-rail (WDDL) to single-rail capture stage. Waits for a
//                full precharge/evaluate cycle on the dual-rail bus, latches
//                the true rail and offers it on a valid/ready handshake.
//                Flags rail faults (p=n=1) and stalled evaluation, and keeps
//                a saturating error count.
//  Revision    : 1.0 - initial release
// ============================================================================
module wddl_dr_capture_32 #(
    parameter int WIDTH     = 32,
    parameter int TIMEOUT   = 15,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     d_p_in,
    input  logic [WIDTH-1:0]     d_n_in,
    output logic [WIDTH-1:0]     d_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 err_fault,
    output logic                 err_timeout,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_PRE  = 2'd1;
    localparam logic [1:0] S_WAIT_EVAL = 2'd2;
    localparam logic [1:0] S_HOLD      = 2'd3;

    localparam logic [TMR_W-1:0]     C_TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [ERR_CNT_W-1:0] C_CNT_MAX  = '1;

    logic [1:0]           state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [WIDTH-1:0]     rp_q, rp_d;
    logic [WIDTH-1:0]     rn_q, rn_d;
    logic [WIDTH-1:0]     d_out_q, d_out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 err_fault_q, err_fault_d;
    logic                 err_timeout_q, err_timeout_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Per-cycle decode of the registered bus
    logic w_pre;
    logic w_done;
    logic w_fault;

    // Events raised by the next-state logic, consumed by the output logic
    logic ev_fault;
    logic ev_timeout;
    logic ev_capture;

    assign w_pre   = ~|(rp_q | rn_q);
    assign w_done  = &(rp_q ^ rn_q);
    assign w_fault = |(rp_q & rn_q);

    // State register plus all datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            rp_q          <= '0;
            rn_q          <= '0;
            d_out_q       <= '0;
            out_valid_q   <= 1'b0;
            err_fault_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            rp_q          <= rp_d;
            rn_q          <= rn_d;
            d_out_q       <= d_out_d;
            out_valid_q   <= out_valid_d;
            err_fault_q   <= err_fault_d;
            err_timeout_q <= err_timeout_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    // Next-state and timer: fault beats pre/done, which beat timeout
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        ev_fault   = 1'b0;
        ev_timeout = 1'b0;
        ev_capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT_PRE;
                    timer_d = '0;
                end
            end
            S_WAIT_PRE: begin
                if (w_fault) begin
                    state_d  = S_IDLE;
                    ev_fault = 1'b1;
                end else if (w_pre) begin
                    state_d = S_WAIT_EVAL;
                    // Timer keeps running into WAIT_EVAL; hold it at the last
                    // value so a late precharge still gets one evaluate check.
                    if (timer_q != C_TMR_LAST) begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end else if (timer_q == C_TMR_LAST) begin
                    state_d    = S_IDLE;
                    ev_timeout = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_WAIT_EVAL: begin
                if (w_fault) begin
                    state_d  = S_IDLE;
                    ev_fault = 1'b1;
                end else if (w_done) begin
                    state_d    = S_HOLD;
                    ev_capture = 1'b1;
                end else if (timer_q == C_TMR_LAST) begin
                    state_d    = S_IDLE;
                    ev_timeout = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_HOLD: begin
                // Bus faults are irrelevant once the word is captured
                if (out_valid_q && out_ready) begin
                    if (start) begin
                        state_d = S_WAIT_PRE;
                        timer_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values
    always_comb begin
        rp_d          = d_p_in;
        rn_d          = d_n_in;
        d_out_d       = ev_capture ? rp_q : d_out_q;
        out_valid_d   = (state_d == S_HOLD);
        err_fault_d   = ev_fault;
        err_timeout_d = ev_timeout;
        err_cnt_d     = err_cnt_q;
        if ((ev_fault || ev_timeout) && (err_cnt_q != C_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign d_out       = d_out_q;
    assign out_valid   = out_valid_q;
    assign busy        = (state_q != S_IDLE);
    assign err_fault   = err_fault_q;
    assign err_timeout = err_timeout_q;
    assign err_cnt     = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wddl_dr_capture_32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wddl_dr_capture_32
//  Description : Directed self-checking bench for wddl_dr_capture_32.
//                Expected captured words go into a scoreboard queue when the
//                evaluate phase is driven and are popped when out_valid shows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wddl_dr_capture_32;

    localparam int W  = 32;
    localparam int TO = 15;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  d_p_in = '0;
    logic [W-1:0]  d_n_in = '0;
    logic [W-1:0]  d_out;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          err_fault;
    logic          err_timeout;
    logic [CW-1:0] err_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    wddl_dr_capture_32 #(.WIDTH(W), .TIMEOUT(TO), .ERR_CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .d_p_in     (d_p_in),
        .d_n_in     (d_n_in),
        .d_out      (d_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .err_fault  (err_fault),
        .err_timeout(err_timeout),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [W-1:0] p, input logic [W-1:0] n);
        d_p_in = p;
        d_n_in = n;
    endtask

    // Drive an evaluate word and record what the capture must yield
    task automatic eval_word(input logic [W-1:0] p);
        bus(p, ~p);
        exp_q.push_back(p);
    endtask

    // Bounded wait for out_valid; latency in cycles is itself checked
    task automatic wait_valid(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check(tag, 64'(n), 64'(exp_lat));
    endtask

    task automatic pop_check(input string tag);
        logic [W-1:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed %0h expected <empty scoreboard>", tag, d_out);
        end else begin
            n_cmp--;
            e = exp_q.pop_front();
            check(tag, 64'(d_out), 64'(e));
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        // ---------------- reset state
        repeat (3) tick();
        check("rst_d_out", 64'(d_out), 64'h0);
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_fault", 64'(err_fault), 64'h0);
        check("rst_tmo", 64'(err_timeout), 64'h0);
        check("rst_cnt", 64'(err_cnt), 64'h0);
        rst_n = 1'b1;
        tick();

        // ---------------- normal capture
        bus('0, '0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("norm_busy", 64'(busy), 64'h1);
        eval_word(32'hA5A55A5A);
        wait_valid("norm_lat", 2);
        pop_check("norm_data");
        consume();
        check("norm_busy_low", 64'(busy), 64'h0);
        check("norm_valid_low", 64'(out_valid), 64'h0);
        check("norm_cnt", 64'(err_cnt), 64'h0);

        // ---------------- backpressure, then back-to-back via HOLD exit
        bus('0, '0);
        start = 1'b1;
        tick();
        start = 1'b0;
        eval_word(32'hFFFF0000);
        wait_valid("bp_lat", 2);
        bus('1, '1);  // faults while holding must be ignored
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 64'(out_valid), 64'h1);
            check("bp_data", 64'(d_out), 64'hFFFF0000);
        end
        check("bp_cnt", 64'(err_cnt), 64'h0);
        pop_check("bp_pop");
        bus('0, '0);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        check("b2b_busy", 64'(busy), 64'h1);
        check("b2b_valid", 64'(out_valid), 64'h0);
        eval_word(32'h00000001);
        wait_valid("b2b_lat", 2);
        pop_check("b2b_data");
        consume();
        check("b2b_idle", 64'(busy), 64'h0);

        // ---------------- rail fault in WAIT_EVAL (bit 7 p=n=1)
        bus('0, '0);
        start = 1'b1;
        tick();
        start = 1'b0;
        bus(32'h00000080, 32'hFFFFFFFF);
        tick();
        check("flt_pre_pulse", 64'(err_fault), 64'h0);
        tick();
        check("flt_pulse", 64'(err_fault), 64'h1);
        check("flt_cnt", 64'(err_cnt), 64'h1);
        check("flt_valid", 64'(out_valid), 64'h0);
        check("flt_busy", 64'(busy), 64'h0);
        tick();
        check("flt_pulse_end", 64'(err_fault), 64'h0);
        check("flt_cnt_hold", 64'(err_cnt), 64'h1);

        // ---------------- timeout with bus stuck at all-zero
        bus('0, '0);
        start = 1'b1;
        tick();
        start = 1'b0;
        begin
            int n;
            n = 0;
            while (!err_timeout && n < TO + 10) begin
                tick();
                n++;
            end
            check("tmo_cycles", 64'(n), 64'(TO));
        end
        check("tmo_cnt", 64'(err_cnt), 64'h2);
        check("tmo_busy", 64'(busy), 64'h0);
        check("tmo_valid", 64'(out_valid), 64'h0);
        tick();
        check("tmo_pulse_end", 64'(err_timeout), 64'h0);

        // ---------------- completion on the last allowed cycle
        bus('0, '0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (TO - 2) tick();
        eval_word(32'h12345678);
        tick();
        tick();
        check("last_valid", 64'(out_valid), 64'h1);
        check("last_tmo", 64'(err_timeout), 64'h0);
        pop_check("last_data");
        consume();
        check("last_cnt", 64'(err_cnt), 64'h2);

        // ---------------- one cycle too late -> timeout
        bus('0, '0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (TO - 1) tick();
        bus(32'h87654321, ~32'h87654321);
        tick();
        check("late_tmo", 64'(err_timeout), 64'h1);
        check("late_cnt", 64'(err_cnt), 64'h3);
        tick();
        check("late_valid", 64'(out_valid), 64'h0);

        // ---------------- start during WAIT_EVAL is ignored
        bus('0, '0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_busy", 64'(busy), 64'h1);
        eval_word(32'h0F0F0F0F);
        wait_valid("ign_lat", 2);
        pop_check("ign_data");
        consume();
        check("ign_idle", 64'(busy), 64'h0);
        tick();
        check("ign_not_queued", 64'(busy), 64'h0);

        // ---------------- asynchronous reset mid-WAIT_EVAL
        bus('0, '0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'h0);
        check("arst_valid", 64'(out_valid), 64'h0);
        check("arst_cnt", 64'(err_cnt), 64'h0);
        check("arst_d_out", 64'(d_out), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_after", 64'(out_valid), 64'h0);

        // ---------------- 300 forced faults saturate the counter
        bus('1, '1);
        start = 1'b1;
        repeat (200) tick();
        check("sat_mid_cnt", 64'(err_cnt), 64'd100);
        repeat (400) tick();
        start = 1'b0;
        check("sat_cnt", 64'(err_cnt), 64'd255);
        bus('0, '0);
        repeat (3) tick();
        check("sat_hold", 64'(err_cnt), 64'd255);

        check("sb_empty", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
